// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot loader for the pipelined processor's instruction memory, and sequencer
// for the CPU's reset. A boot sequence runs in four steps:
//   1. Zero-fill every memory word.
//   2. Accept a program as a valid/ready word stream and write it from
//      address 0 upward.
//   3. Hold the CPU in reset for RST_HOLD cycles.
//   4. Release the CPU.
// A bench or host loads the program through these ports. No backdoor memory
// loading or hierarchical PC forcing is needed.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN. The in_last word is then
// treated as a checksum. The DATA_W-bit running sum of all accepted words,
// including the checksum word, must be zero at in_last. If it is not, the
// sequence goes to the error state instead of releasing the CPU.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_start        one-cycle request to begin a boot sequence
//   i_in_valid     stream word valid
//   i_in_data      stream word
//   i_in_last      marks the final program word
//   o_in_ready     loader accepts a word this cycle
//   o_mem_we       instruction memory write enable (registered)
//   o_mem_addr     instruction memory write address (registered)
//   o_mem_wdata    instruction memory write data (registered)
//   o_cpu_rst_n    active-low reset to the CPU
//   o_busy         high during clear, load and hold
//   o_done         CPU released and running
//   o_error        load failed; CPU held in reset
//   o_word_count   words accepted in the current load (saturates at DEPTH)
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int RST_HOLD = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_last,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_cpu_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_word_count
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [ADDR_W:0]   LP_DEPTH     = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_CLR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [HOLD_W-1:0] LP_HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_ERR
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_in_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_cpu_rst_n;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [ADDR_W:0]     r_word_count;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                w_clr_wr;
  logic                w_load_wr;
  logic                w_enter_clear;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   r_sum;
  logic [DATA_W-1:0]   w_sum_next;
`endif

  // Next-state decode.
  // A handshake that arrives when DEPTH words are already stored is an
  // overflow. That word is dropped rather than written, and the load fails.
  always_comb begin
    w_next    = r_state;
    w_clr_wr  = 1'b0;
    w_load_wr = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    w_sum_next = r_sum + i_in_data;
`endif
    case (r_state)
      S_IDLE, S_RUN, S_ERR: begin
        if (i_start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        w_clr_wr = 1'b1;
        if (r_clr_addr == LP_CLR_LAST) w_next = S_LOAD;
      end
      S_LOAD: begin
        if (i_in_valid && r_in_ready) begin
          if (r_word_count == LP_DEPTH) begin
            w_next = S_ERR;
          end else begin
            w_load_wr = 1'b1;
            if (i_in_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              w_next = (w_sum_next == '0) ? S_HOLD : S_ERR;
`else
              w_next = S_HOLD;
`endif
            end
          end
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == LP_HOLD_LAST) w_next = S_RUN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_clear = (w_next == S_CLEAR) && (r_state != S_CLEAR);

  // State and output registers.
  // The status outputs are decoded from the next state. They therefore change
  // in the same cycle as the state they describe. For example, cpu_rst_n
  // drops the cycle after a reboot start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_rst_n  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_word_count <= '0;
      r_clr_addr   <= '0;
      r_hold_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == S_LOAD);
      r_cpu_rst_n <= (w_next == S_RUN);
      r_done      <= (w_next == S_RUN);
      r_error     <= (w_next == S_ERR);
      r_busy      <= (w_next == S_CLEAR) || (w_next == S_LOAD) || (w_next == S_HOLD);
      r_mem_we    <= w_clr_wr || w_load_wr;

      if (w_clr_wr) begin
        r_mem_addr  <= r_clr_addr;
        r_mem_wdata <= '0;
      end else if (w_load_wr) begin
        r_mem_addr  <= r_word_count[ADDR_W-1:0];
        r_mem_wdata <= i_in_data;
      end

      if (w_enter_clear) begin
        r_clr_addr   <= '0;
        r_word_count <= '0;
      end else begin
        if (w_clr_wr)  r_clr_addr   <= r_clr_addr + ADDR_W'(1);
        if (w_load_wr) r_word_count <= r_word_count + (ADDR_W+1)'(1);
      end

      r_hold_cnt <= (r_state == S_HOLD) ? r_hold_cnt + HOLD_W'(1) : '0;

`ifdef IMEM_LOADER_CHECKSUM_EN
      if (w_enter_clear)  r_sum <= '0;
      else if (w_load_wr) r_sum <= w_sum_next;
`endif
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_cpu_rst_n  = r_cpu_rst_n;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_word_count = r_word_count;

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised instruction-memory boot loader and CPU reset sequencer for the pipelined processor. It zero-fills instruction memory, accepts a program as a valid/ready word stream and writes it from address 0 upward. It holds the CPU in reset for a fixed number of cycles after loading, then releases it. It replaces backdoor memory loading and hierarchical PC forcing: a bench or host streams the program in through ports.

## Interface
Parameters:
- DATA_W, 8, instruction word width
- ADDR_W, 8, memory address width
- DEPTH, 256, number of memory words (≤ 2^ADDR_W)
- RST_HOLD, 4, cycles the CPU is kept in reset after the load completes (≥ 1)

Ports:
- CLK  in  1  single clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a boot sequence
- in_valid  in  1  stream word valid
- in_data  in  DATA_W  stream word
- in_last  in  1  marks final word of the program
- in_ready  out  1  loader accepts a word this cycle
- mem_we  out  1  instruction memory write enable
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- cpu_rst_n  out  1  active-low reset to the CPU's RST port
- busy  out  1  sequence in progress (CLEAR, LOAD or HOLD)
- done  out  1  CPU released and running
- error  out  1  load failed; CPU remains in reset
- word_count  out  ADDR_W+1  words accepted in the current load

## Operation
- States: IDLE, CLEAR, LOAD, HOLD, RUN, ERR.
- IDLE: cpu_rst_n=0. start → CLEAR; word_count, error and done are cleared.
- CLEAR: writes 0 to addresses 0..DEPTH-1, one per cycle; after address DEPTH-1 → LOAD.
- LOAD: in_ready=1. Each in_valid&&in_ready transfer writes in_data to address word_count, then word_count increments.
  - Transfer with in_last=1 → HOLD.
  - A transfer that would be word DEPTH+1 (in_last never seen within DEPTH words) → ERR. That word is not written and in_ready drops.
- HOLD: cpu_rst_n=0 for RST_HOLD cycles, then → RUN.
- RUN: cpu_rst_n=1, done=1. start → CLEAR, which reboots and re-asserts cpu_rst_n the next cycle.
- ERR: error=1, cpu_rst_n=0. start → CLEAR; otherwise the loader stays in ERR.
- start is ignored in CLEAR, LOAD and HOLD.
- A write of word DEPTH with in_last=1 is legal: it fills memory exactly.
- word_count saturates at DEPTH and does not wrap.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
  - cpu_rst_n=0, busy=0, done=0, error=0, word_count=0
- RST mid-sequence aborts in the cycle it is sampled: next edge gives the reset values, with no partial write.
- mem_we, mem_addr and mem_wdata are registered, one cycle after a CLEAR step or stream handshake.
- in_ready is a registered state decode: high from the first LOAD cycle, low the cycle after the in_last handshake.
- CLEAR takes exactly DEPTH cycles.
- cpu_rst_n rises RST_HOLD cycles after entering HOLD. done rises in the same cycle. The final mem_we pulse lands in the first HOLD cycle, before release.
- Boot latency for N words at full throughput: 1 (start) + DEPTH + N + RST_HOLD cycles.
- busy=1 throughout CLEAR, LOAD and HOLD.
- Simultaneous start and RST: RST wins.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - The in_last word is a checksum and is still written to memory.
  - A running DATA_W-bit sum (mod 2^DATA_W) of all accepted words, checksum included, must equal 0 at in_last; otherwise → ERR instead of HOLD.
  - The sum clears on entering CLEAR.
- Undefined: no checksum logic; in_last always → HOLD.

## Test plan
- Basic boot (DEPTH=256, RST_HOLD=4): start, stream 3 words 0x11, 0x22, 0x33 (last) → 256 zero writes, then writes to addr 0..2; cpu_rst_n rises 4 cycles later; done=1; word_count=3.
- Backpressure-free gaps: in_valid toggled 1/0 for 5 words → exactly 5 writes, consecutive addresses, no duplicates; in_ready stays 1 until the last handshake.
- Overflow (DEPTH=4): stream 5 words, none with in_last → 4 writes, error=1, cpu_rst_n=0, fifth word not written; start then reboots cleanly.
- Reset mid-LOAD: RST after 2 of 4 words → next cycle all outputs at reset values, no further mem_we; a fresh start runs the full CLEAR.
- Reboot from RUN: start while done=1 → cpu_rst_n=0 the following cycle, memory re-cleared, new program loaded.
- With IMEM_LOADER_CHECKSUM_EN: stream 0x10, 0x20, 0xD0 (last, sum 0x00) → RUN; stream 0x10, 0x20, 0xD1 → error=1, CPU held in reset.
